// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol serializer: modulation encodings and
// helpers that size symbols and words per modulation mode.
package qam_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_QAM16 = 2'b10,
    MODE_RSVD  = 2'b11
  } mod_mode_t;

  // The reserved encoding falls back to the widest symbol.
  function automatic int unsigned bps_of(input logic [1:0] mode);
    case (mode)
      MODE_BPSK: return 1;
      MODE_QPSK: return 2;
      default:   return 4;
    endcase
  endfunction

  function automatic int unsigned syms_per_word(input logic [1:0] mode,
                                                input int unsigned data_width);
    case (mode)
      MODE_BPSK: return data_width;
      MODE_QPSK: return data_width / 2;
      default:   return data_width / 4;
    endcase
  endfunction

endpackage

// File: rtl/qam_word_buffer.sv
// Hold register for one input word together with the mode and tlast that were
// sampled alongside it; filled on an input beat, emptied when its word moves on.
module qam_word_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wr_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]            wr_mode,
  input  logic                  wr_last,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            mode,
  output logic                  last
);

  // A write wins over a clear; the top never asks for both in one cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= 2'b00;
      last  <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
      mode  <= wr_mode;
      last  <= wr_last;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qam_symbol_serializer.sv
// Word-to-symbol serializer: double-buffered AXI-Stream words are sliced into
// 1/2/4-bit symbols, emitted LSB-justified one per downstream beat.
module qam_symbol_serializer
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SYM_MAX    = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            mod_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [SYM_MAX-1:0]    m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [1:0]            hold_mode;
  logic                  hold_last;

  logic                  shift_valid;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [1:0]            shift_mode;
  logic                  shift_last;
  logic [CNT_W-1:0]      sym_cnt;
  logic [CNT_W-1:0]      last_idx;

  logic s_beat;
  logic m_beat;
  logic last_sym;
  logic load;
  logic bypass;
  logic hold_wr;
  logic [SYM_MAX-1:0] cur_sym;

  assign s_axis_tready = !hold_valid;
  assign s_beat        = s_axis_tvalid & !hold_valid;
  assign m_beat        = shift_valid & m_axis_tready;
  assign last_idx      = CNT_W'(syms_per_word(shift_mode, DATA_WIDTH) - 1);
  assign last_sym      = (sym_cnt == last_idx);
  assign load          = hold_valid & (!shift_valid | (m_beat & last_sym));
  assign bypass        = s_beat & !shift_valid;
  assign hold_wr       = s_beat & !bypass;

  qam_word_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (hold_wr),
    .clear   (load),
    .wr_data (s_axis_tdata),
    .wr_mode (mod_mode),
    .wr_last (s_axis_tlast),
    .valid   (hold_valid),
    .data    (hold_data),
    .mode    (hold_mode),
    .last    (hold_last)
  );

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w,
                                                    input logic [1:0] mode);
    int unsigned b;
    b = bps_of(mode);
    return MSB_FIRST ? (w << b) : (w >> b);
  endfunction

  // The current symbol always sits at the outgoing end of the shift register.
  always_comb begin
    cur_sym = '0;
    case (shift_mode)
      MODE_BPSK: cur_sym[0]   = MSB_FIRST ? shift_reg[DATA_WIDTH-1]      : shift_reg[0];
      MODE_QPSK: cur_sym[1:0] = MSB_FIRST ? shift_reg[DATA_WIDTH-1 -: 2] : shift_reg[1:0];
      default:   cur_sym[3:0] = MSB_FIRST ? shift_reg[DATA_WIDTH-1 -: 4] : shift_reg[3:0];
    endcase
  end

  // A reload on the final symbol's beat keeps the output stream gap-free.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shift_valid <= 1'b0;
      shift_reg   <= '0;
      shift_mode  <= 2'b00;
      shift_last  <= 1'b0;
      sym_cnt     <= '0;
    end else if (load) begin
      shift_valid <= 1'b1;
      shift_reg   <= hold_data;
      shift_mode  <= hold_mode;
      shift_last  <= hold_last;
      sym_cnt     <= '0;
    end else if (bypass) begin
      shift_valid <= 1'b1;
      shift_reg   <= s_axis_tdata;
      shift_mode  <= mod_mode;
      shift_last  <= s_axis_tlast;
      sym_cnt     <= '0;
    end else if (m_beat) begin
      if (last_sym) begin
        shift_valid <= 1'b0;
      end else begin
        shift_reg <= advance(shift_reg, shift_mode);
        sym_cnt   <= sym_cnt + CNT_W'(1);
      end
    end
  end

  assign m_axis_tvalid = shift_valid;
  assign m_axis_tdata  = cur_sym;
  assign m_axis_tlast  = shift_valid & shift_last & last_sym;
  assign busy          = hold_valid | shift_valid;

endmodule

// File: tb/tb_qam_symbol_serializer.sv
// Bench: two serializers (MSB-first and LSB-first) share one input stream and
// are scored against symbol queues built arithmetically from each accepted word.
module tb_qam_symbol_serializer;

  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    mod_mode;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          m_tready;
  logic          s_tready_m, s_tready_l;
  logic [3:0]    m_tdata_m, m_tdata_l;
  logic          m_tvalid_m, m_tvalid_l;
  logic          m_tlast_m, m_tlast_l;
  logic          busy_m, busy_l;

  typedef struct {
    logic [3:0] sym;
    logic       last;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];

  int   vec_cnt = 0;
  int   miscompares = 0;
  int   ready_policy = 0;
  int   cycle = 0;
  int   beats_m, beats_l, lasts_m, first_beat, last_beat, s_first;
  logic s_beat_seen = 1'b0;

  always #5 aclk = ~aclk;

  qam_symbol_serializer #(.DATA_WIDTH(DW), .SYM_MAX(4), .MSB_FIRST(1'b1)) dut_msb (
    .aclk(aclk), .areset(areset), .mod_mode(mod_mode),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_m),
    .m_axis_tdata(m_tdata_m), .m_axis_tvalid(m_tvalid_m), .m_axis_tlast(m_tlast_m),
    .m_axis_tready(m_tready), .busy(busy_m)
  );

  qam_symbol_serializer #(.DATA_WIDTH(DW), .SYM_MAX(4), .MSB_FIRST(1'b0)) dut_lsb (
    .aclk(aclk), .areset(areset), .mod_mode(mod_mode),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_l),
    .m_axis_tdata(m_tdata_l), .m_axis_tvalid(m_tvalid_l), .m_axis_tlast(m_tlast_l),
    .m_axis_tready(m_tready), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected symbols of one word for both bit orders; reserved mode acts as QAM16.
  function automatic void push_word(input logic [31:0] w, input logic [1:0] mode, input logic last);
    int bps;
    int n;
    int mask;
    bps  = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    n    = DW / bps;
    mask = (1 << bps) - 1;
    for (int k = 0; k < n; k++) begin
      q_m.push_back('{sym: 4'((w >> (DW - (k + 1) * bps)) & mask), last: last && (k == n - 1)});
      q_l.push_back('{sym: 4'((w >> (k * bps)) & mask), last: last && (k == n - 1)});
    end
  endfunction

  task automatic reset_counters();
    beats_m = 0; beats_l = 0; lasts_m = 0;
    first_beat = -1; last_beat = -1; s_first = -1;
  endtask

  task automatic observe();
    if (m_tvalid_m) begin
      check("m_sym_expected_msb", 32'(q_m.size() != 0), 1);
      if (q_m.size() != 0) begin
        check("m_tdata_msb", m_tdata_m, q_m[0].sym);
        check("m_tlast_msb", m_tlast_m, q_m[0].last);
        if (m_tready) begin
          void'(q_m.pop_front());
          beats_m++;
          if (m_tlast_m) lasts_m++;
          if (first_beat < 0) first_beat = cycle;
          last_beat = cycle;
        end
      end
    end
    if (m_tvalid_l) begin
      check("m_sym_expected_lsb", 32'(q_l.size() != 0), 1);
      if (q_l.size() != 0) begin
        check("m_tdata_lsb", m_tdata_l, q_l[0].sym);
        check("m_tlast_lsb", m_tlast_l, q_l[0].last);
        if (m_tready) begin
          void'(q_l.pop_front());
          beats_l++;
        end
      end
    end
    s_beat_seen = s_tvalid && s_tready_m && s_tready_l;
    if (s_beat_seen) begin
      if (s_first < 0) s_first = cycle;
      push_word(s_tdata, mod_mode, s_tlast);
    end
  endtask

  // Called at a falling edge: drive ready, sample just after, then cross one rising edge.
  task automatic tick();
    case (ready_policy)
      1: m_tready = 1'($urandom_range(0, 1));
      2: m_tready = ~m_tready;
      default: ;
    endcase
    #1;
    observe();
    @(posedge aclk);
    cycle++;
    @(negedge aclk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int budget;
    budget   = 300;
    s_tvalid = 1'b1;
    s_tdata  = w;
    s_tlast  = last;
    do begin
      tick();
      budget--;
    end while (!s_beat_seen && budget > 0);
    check("s_beat_accepted", 32'(s_beat_seen), 1);
  endtask

  task automatic drain(input int budget);
    int left;
    left     = budget;
    s_tvalid = 1'b0;
    while ((q_m.size() != 0 || q_l.size() != 0) && left > 0) begin
      tick();
      left--;
    end
    check("drain_done", 32'(q_m.size() + q_l.size()), 0);
    #1;
    check("idle_tvalid_msb", m_tvalid_m, 0);
    check("idle_tvalid_lsb", m_tvalid_l, 0);
    check("idle_busy_msb", busy_m, 0);
    check("idle_s_tready", s_tready_m, 1);
  endtask

  initial begin
    areset = 1'b1; mod_mode = 2'd0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    reset_counters();
    repeat (2) @(negedge aclk);
    #1;
    check("rst_tvalid", m_tvalid_m, 0);
    check("rst_tdata", m_tdata_m, 0);
    check("rst_tlast", m_tlast_m, 0);
    check("rst_busy", busy_l, 0);
    check("rst_s_tready", s_tready_m, 1);
    areset = 1'b0;
    @(negedge aclk);

    // 1) QAM16 single word, first symbol one cycle after the input beat
    ready_policy = 0; m_tready = 1'b1; mod_mode = 2'd2;
    reset_counters();
    send_word(32'h1234_5678, 1'b0);
    s_tvalid = 1'b0;
    #1;
    check("t1_first_valid", m_tvalid_m, 1);
    check("t1_first_sym", m_tdata_m, 4'h1);
    drain(100);
    check("t1_beats", beats_m, 8);
    check("t1_latency", first_beat, s_first + 1);
    check("t1_contig", last_beat - first_beat + 1, 8);

    // 2) QPSK, LSB-first instance yields 0,1,2,3 then zeros
    mod_mode = 2'd1;
    reset_counters();
    send_word(32'h0000_00E4, 1'b0);
    s_tvalid = 1'b0;
    #1;
    check("t2_first_sym_lsb", m_tdata_l, 0);
    drain(100);
    check("t2_beats_lsb", beats_l, 16);

    // 3) back-to-back QAM16 words, tlast on the second
    mod_mode = 2'd2;
    reset_counters();
    send_word(32'hAAAA_AAAA, 1'b0);
    send_word(32'h5555_5555, 1'b1);
    s_tvalid = 1'b0;
    #1;
    check("t3_s_tready_full", s_tready_m, 0);
    check("t3_busy", busy_m, 1);
    drain(100);
    check("t3_beats", beats_m, 16);
    check("t3_contig", last_beat - first_beat + 1, 16);
    check("t3_latency", first_beat, s_first + 1);
    check("t3_tlast_count", lasts_m, 1);

    // 4) downstream ready toggling 1010 mid-word
    ready_policy = 2; m_tready = 1'b1;
    reset_counters();
    send_word(32'h9A3C_71E5, 1'b1);
    drain(200);
    check("t4_beats", beats_m, 8);
    check("t4_tlast_count", lasts_m, 1);
    ready_policy = 0; m_tready = 1'b1;

    // 5) mode switched to BPSK while word 1 drains
    mod_mode = 2'd2;
    reset_counters();
    send_word(32'h0F1E_2D3C, 1'b0);
    mod_mode = 2'd0;
    send_word(32'h8000_0001, 1'b1);
    mod_mode = 2'd2;
    drain(200);
    check("t5_beats_msb", beats_m, 40);
    check("t5_beats_lsb", beats_l, 40);
    check("t5_tlast_count", lasts_m, 1);

    // 6) reset pulsed after three symbols of a word
    reset_counters();
    send_word(32'hFEDC_BA98, 1'b0);
    s_tvalid = 1'b0;
    repeat (3) tick();
    check("t6_pre_beats", beats_m, 3);
    areset = 1'b1;
    #1;
    check("t6_rst_tvalid", m_tvalid_m, 0);
    check("t6_rst_tdata", m_tdata_m, 0);
    check("t6_rst_tlast", m_tlast_m, 0);
    check("t6_rst_busy", busy_m, 0);
    check("t6_rst_s_tready", s_tready_l, 1);
    q_m.delete();
    q_l.delete();
    tick();
    areset = 1'b0;
    reset_counters();
    repeat (6) tick();
    check("t6_no_symbols", beats_m + beats_l, 0);
    check("t6_s_tready", s_tready_m, 1);

    // Randomized words, modes, gaps and backpressure
    ready_policy = 1;
    reset_counters();
    for (int i = 0; i < 150; i++) begin
      int gap;
      mod_mode = 2'($urandom_range(0, 3));
      send_word($urandom, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        s_tvalid = 1'b0;
        repeat (gap) tick();
      end
    end
    drain(8000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
